bc_seg7_scan: RTL and testbench
===============================

Name: bc_seg7_scan

Overview:
- Display back-end for the Bulls & Cows game on the Nexys A7. It consumes the symbols the game core produces (secrets, guesses, bulls/cows counts, prompts) and drives the 8-digit multiplexed 7-segment display (an/digit).
- The game core writes a whole 8-symbol frame with a load pulse. The block double-buffers it and commits it only at a scan-frame boundary, so the display never tears.
- Adds per-digit blanking and blink.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot (1 kHz slot rate at 100 MHz); minimum 2.
- BLINK_FRAMES, 64: full 8-slot frames per blink half-period; minimum 1.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: single-cycle request to capture sym_in and blink_mask into the shadow buffer.
- sym_in, input, 40: 8 symbols x 5 bits; sym_in[4:0] = digit 0 (rightmost, an[0]), sym_in[39:35] = digit 7.
- blink_mask, input, 8: bit i=1 makes digit i blink.
- busy, output, 1: shadow holds an uncommitted frame.
- ack, output, 1: one-cycle pulse when the shadow frame is committed to the active buffer.
- an, output, 8: anode selects, active low.
- digit, output, 7: segments {g,f,e,d,c,b,a}, active low; no DP.

Behaviour:
- Reset (synchronous, all outputs registered):
  - an=8'hFF, digit=7'h7F, busy=0, ack=0.
  - Active and shadow symbols = BLANK, masks=0.
  - Prescaler=0, slot=0, frame counter=0, blink phase=0.
- Prescaler: counts 0..REFRESH_DIV-1. Terminal count (tc) advances slot 0->1->...->7->0 (wrap).
- Frame boundary: the tc cycle with slot==7.
  - Frame counter increments.
  - When the counter reaches BLINK_FRAMES-1 it clears and the blink phase toggles.
- Commit: on a frame boundary with busy=1:
  - active <= shadow.
  - busy <= 0.
  - ack=1 for exactly that one cycle.
- Load:
  - load=1 writes the shadow and sets busy=1 in the next cycle.
  - A load while busy overwrites the shadow; only one ack results.
  - A load coincident with a commit: the commit takes the old shadow and ack pulses. The new data lands in the shadow and busy stays 1, so a second ack follows at the next boundary.
- Output stage, registered, updating one cycle after slot changes:
  - Digit i is off (an[i]=1, digit=7'h7F) if its active symbol is BLANK, or if blink phase=1 and its active blink bit=1.
  - Otherwise an = ~(8'b1<<slot) and digit = decode(active[slot]).
  - Exactly zero or one an bit is low at any time.
- Symbol codes (5-bit):
  - 0x00-0x0F: hex 0-F.
  - 0x10: BLANK.
  - 0x11: DASH (0111111).
  - 0x12: P (0001100).
  - 0x13: r (0101111).
  - 0x14-0x1F: decode as BLANK.
- Hex patterns (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-frame:
  - Pending shadow data is discarded and no ack is issued.
  - Scanning restarts at slot 0 with a blank display.

Decomposition:
- Package bc_display_pkg:
  - sym_t, a 5-bit enum: HEX0..HEXF, BLANK, DASH, P, R.
  - Constants SEG_OFF=7'h7F and AN_OFF=8'hFF.
  - The hex/letter segment patterns.
- Sub-module bc_seg7_decode: combinational, sym_t -> 7-bit active-low segments. It is instantiated once, on the selected active symbol.

Test Plan (sim with REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset check: hold reset 3 cycles -> an=FF, digit=7F, busy=0, ack=0. With no load, an stays FF for 5 full frames, since all symbols are BLANK.
- Load and scan: load sym_in={7,6,5,4,3,2,1,0} at cycle 5.
  - busy=1 at cycle 6.
  - ack pulses once at the first slot-7 tc.
  - Then an walks FE,FD,...,7F, 4 cycles each. Digit 0 shows 1000000 with an=FE, and digit 7 shows 1111000 with an=7F.
  - 7F is followed by FE (wrap).
- Overwrite while pending: two loads (all-8, then all-DASH) before the boundary -> exactly one ack; every digit shows 0111111.
- Load on commit cycle: load all-P on the boundary cycle, with all-8 pending -> ack that cycle and the display shows 0000000 for one frame. busy stays 1; a second ack follows one frame later, after which P (0001100) is shown.
- Blink and blank: symbol 0x10 on digit 3 plus blink_mask=8'h01 -> an[3] is never low. an[0] is low for 2 frames, then high for 2 frames, repeating. Symbol 0x1F decodes as off.
- Mid-frame reset: assert reset in slot 4 with a load pending -> an=FF next cycle, no ack ever for that load, slot restarts at 0.

Source files
------------

// File: rtl/bc_display_pkg.sv
// Symbol codes and segment patterns shared by the Bulls & Cows display back-end.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package bc_display_pkg;

  typedef enum logic [4:0] {
    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7,
    HEX8, HEX9, HEXA, HEXB, HEXC, HEXD, HEXE, HEXF,
    BLANK, DASH, P, R
  } sym_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_R    = 7'b0101111;

endpackage

// File: rtl/bc_seg7_scan_if.sv
// Frame hand-off between the game core (master) and the display back-end (slave).
interface bc_seg7_scan_if;
  import bc_display_pkg::*;

  logic        load;
  logic [39:0] sym_in;
  logic [7:0]  blink_mask;
  logic        busy;
  logic        ack;

  modport master (output load, output sym_in, output blink_mask, input busy, input ack);
  modport slave  (input load, input sym_in, input blink_mask, output busy, output ack);

endinterface

// File: rtl/bc_seg7_decode.sv
// Symbol to active-low 7-segment pattern; unassigned codes render as blank.
module bc_seg7_decode
  import bc_display_pkg::*;
(
  input  sym_t       sym,
  output logic [6:0] seg
);

  logic [4:0] code;
  assign code = sym;

  always_comb begin
    seg = SEG_OFF;
    if (code < 5'h10) begin
      seg = SEG_HEX[code[3:0]];
    end else begin
      case (sym)
        DASH:    seg = SEG_DASH;
        P:       seg = SEG_P;
        R:       seg = SEG_R;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/bc_seg7_scan.sv
// 8-digit multiplexed 7-segment scanner with a double-buffered frame that only
// commits on a scan-frame boundary, plus per-digit blanking and blink.
//
//   state      | meaning
//   SH_EMPTY   | shadow matches active, nothing to commit
//   SH_PENDING | shadow holds a frame waiting for the next frame boundary
module bc_seg7_scan
  import bc_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clock,
  input  logic             reset,
  bc_seg7_scan_if.slave    bus,
  output logic [7:0]       an,
  output logic [6:0]       digit
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {SH_EMPTY, SH_PENDING} sh_state_t;

  sh_state_t     state, state_nxt;
  logic [PW-1:0] pre;
  logic [2:0]    slot;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic          tc, boundary, commit, ack_q;
  sym_t          act_sym [8];
  sym_t          sh_sym  [8];
  logic [7:0]    act_blink, sh_blink;
  logic [6:0]    cur_seg;
  logic          cur_off;

  assign tc       = (pre == P_LAST);
  assign boundary = tc && (slot == 3'd7);
  assign bus.busy = (state == SH_PENDING);
  assign bus.ack  = ack_q;

  always_ff @(posedge clock) begin
    if (reset) state <= SH_EMPTY;
    else       state <= state_nxt;
  end

  // A load landing on the commit cycle keeps the FSM pending for the next frame.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      SH_EMPTY: begin
        if (bus.load) state_nxt = SH_PENDING;
      end
      SH_PENDING: begin
        if (boundary) begin
          commit = 1'b1;
          if (!bus.load) state_nxt = SH_EMPTY;
        end
      end
      default: state_nxt = SH_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre   <= '0;
      slot  <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      pre <= tc ? '0 : pre + PW'(1);
      if (tc) slot <= slot + 3'd1;
      if (boundary) begin
        if (fcnt == F_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        act_sym[i] <= BLANK;
        sh_sym[i]  <= BLANK;
      end
      act_blink <= '0;
      sh_blink  <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= commit;
      if (commit) begin
        act_sym   <= sh_sym;
        act_blink <= sh_blink;
      end
      if (bus.load) begin
        for (int i = 0; i < 8; i++) sh_sym[i] <= sym_t'(bus.sym_in[5*i +: 5]);
        sh_blink <= bus.blink_mask;
      end
    end
  end

  bc_seg7_decode u_decode (
    .sym (act_sym[slot]),
    .seg (cur_seg)
  );

  assign cur_off = (cur_seg == SEG_OFF) || (phase && act_blink[slot]);

  always_ff @(posedge clock) begin
    if (reset) begin
      an    <= AN_OFF;
      digit <= SEG_OFF;
    end else begin
      an    <= cur_off ? AN_OFF  : ~(8'b1 << slot);
      digit <= cur_off ? SEG_OFF : cur_seg;
    end
  end

endmodule

// File: tb/tb_bc_seg7_scan.sv
// Bench for bc_seg7_scan: time-based reference model of scan position, blink
// phase and frame commits, checked every cycle one step after the clock edge.
module tb_bc_seg7_scan;

  localparam int D  = 4;
  localparam int BF = 2;
  localparam int FR = 8 * D;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] an;
  logic [6:0] digit;

  bc_seg7_scan_if bus ();

  bc_seg7_scan #(.REFRESH_DIV(D), .BLINK_FRAMES(BF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .an    (an),
    .digit (digit)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: t counts clock edges since reset release.
  int         t;
  logic [4:0] m_act [8];
  logic [4:0] m_sh  [8];
  logic [7:0] m_bl, m_shbl;
  bit         m_busy;
  logic [7:0] exp_an;
  logic [6:0] exp_digit;
  logic       exp_busy, exp_ack;

  localparam logic [6:0] HEXPAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg_of(input logic [4:0] s);
    if (s < 5'h10)  return HEXPAT[s[3:0]];
    if (s == 5'h11) return 7'b0111111;
    if (s == 5'h12) return 7'b0001100;
    if (s == 5'h13) return 7'b0101111;
    return 7'h7F;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 5'h10;
      m_sh[i]  = 5'h10;
    end
    m_bl = '0; m_shbl = '0; m_busy = 0;
  endtask

  task automatic drive(input logic ld, input logic [39:0] sym, input logic [7:0] mask);
    bus.load = ld; bus.sym_in = sym; bus.blink_mask = mask;
  endtask

  // Predict the post-edge outputs, advance one clock, then update the model.
  task automatic step();
    int s, ph;
    bit bnd, off;
    bnd = 0;
    if (reset) begin
      exp_an = 8'hFF; exp_digit = 7'h7F; exp_busy = 0; exp_ack = 0;
    end else begin
      s   = (t / D) % 8;
      ph  = ((t / FR) / BF) % 2;
      bnd = (t % FR) == FR - 1;
      off = (m_act[s] == 5'h10) || (m_act[s] >= 5'h14) || (ph == 1 && m_bl[s]);
      exp_an    = off ? 8'hFF : ~(8'h01 << s);
      exp_digit = off ? 7'h7F : seg_of(m_act[s]);
      exp_ack   = bnd && m_busy;
      exp_busy  = bus.load || (m_busy && !bnd);
    end
    @(posedge clock);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (bnd && m_busy) begin
        m_act = m_sh;
        m_bl  = m_shbl;
      end
      if (bus.load) begin
        for (int i = 0; i < 8; i++) m_sh[i] = bus.sym_in[5*i +: 5];
        m_shbl = bus.blink_mask;
      end
      m_busy = exp_busy;
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0);
    repeat (3) begin
      step(); n_vec++;
      if (an !== 8'hFF || digit !== 7'h7F || bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: an=%h digit=%b busy=%b ack=%b, expected ff 1111111 0 0", an, digit, bus.busy, bus.ack);
      end
    end
    reset = 1'b0;
    repeat (5 * FR) begin
      step(); n_vec++;
      if (an !== 8'hFF || digit !== 7'h7F || bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d: an=%h digit=%b busy=%b ack=%b, expected ff 1111111 0 0", t, an, digit, bus.busy, bus.ack);
      end
    end
  endtask

  task automatic test_load_scan();
    int acks = 0;
    logic [7:0] prev;
    repeat (5) begin
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL scan_idle t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
    end
    drive(1'b1, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00);
    step(); n_vec++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_load: busy=%b, expected 1", bus.busy);
    end
    drive(1'b0, '0, '0);
    prev = an;
    repeat (3 * FR) begin
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL scan t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
      if (bus.ack === 1'b1) acks++;
      if (an == 8'hFE) begin
        n_vec++;
        if (digit !== 7'b1000000) begin
          n_fail++; $display("FAIL digit0: digit=%b, expected 1000000", digit);
        end
      end
      if (an == 8'h7F) begin
        n_vec++;
        if (digit !== 7'b1111000) begin
          n_fail++; $display("FAIL digit7: digit=%b, expected 1111000", digit);
        end
      end
      if (prev == 8'h7F && an != 8'h7F) begin
        n_vec++;
        if (an !== 8'hFE) begin
          n_fail++; $display("FAIL scan_wrap: an=%h, expected fe", an);
        end
      end
      prev = an;
    end
    n_vec++;
    if (acks != 1) begin
      n_fail++; $display("FAIL scan_ack_count: got %0d acks, expected 1", acks);
    end
  endtask

  task automatic test_overwrite();
    int acks = 0;
    for (int k = 0; k < FR && (t % FR) != 0; k++) step();
    drive(1'b1, {8{5'h08}}, 8'h00); step();
    drive(1'b0, '0, '0);            step(); step();
    drive(1'b1, {8{5'h11}}, 8'h00); step();
    drive(1'b0, '0, '0);
    for (int k = 0; k < 2 * FR; k++) begin
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL overwrite t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
      if (bus.ack === 1'b1) acks++;
      if (k >= FR && an != 8'hFF) begin
        n_vec++;
        if (digit !== 7'b0111111) begin
          n_fail++; $display("FAIL overwrite_dash: digit=%b, expected 0111111", digit);
        end
      end
    end
    n_vec++;
    if (acks != 1) begin
      n_fail++; $display("FAIL overwrite_ack_count: got %0d acks, expected 1", acks);
    end
  endtask

  task automatic test_load_on_commit();
    int acks = 0;
    for (int k = 0; k < FR && (t % FR) != 0; k++) step();
    drive(1'b1, {8{5'h08}}, 8'h00); step();
    drive(1'b0, '0, '0);
    for (int k = 0; k < FR && (t % FR) != FR - 1; k++) step();
    drive(1'b1, {8{5'h12}}, 8'h00);
    step(); n_vec++;
    if (bus.ack !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL commit_cycle: ack=%b busy=%b, expected 1 1", bus.ack, bus.busy);
    end
    if (bus.ack === 1'b1) acks++;
    drive(1'b0, '0, '0);
    for (int k = 0; k < 2 * FR; k++) begin
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL load_on_commit t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
      if (bus.ack === 1'b1) acks++;
      if (an != 8'hFF) begin
        n_vec++;
        if (digit !== ((k < FR) ? 7'b0000000 : 7'b0001100)) begin
          n_fail++; $display("FAIL commit_frames k=%0d: digit=%b, expected %b", k, digit, (k < FR) ? 7'b0000000 : 7'b0001100);
        end
      end
    end
    n_vec++;
    if (acks != 2) begin
      n_fail++; $display("FAIL commit_ack_count: got %0d acks, expected 2", acks);
    end
  endtask

  task automatic test_blink_blank();
    bit seen = 0;
    int lows = 0;
    drive(1'b1, {5'h01, 5'h02, 5'h1F, 5'h04, 5'h10, 5'h05, 5'h06, 5'h07}, 8'h01);
    step();
    drive(1'b0, '0, '0);
    for (int k = 0; k < 2 * FR && !seen; k++) begin
      step();
      if (bus.ack === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_fail++; $display("FAIL blink_ack_timeout: ack=0, expected 1 within %0d cycles", 2 * FR);
    end
    repeat (8 * FR) begin
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL blink t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
      n_vec++;
      if (an[3] !== 1'b1 || an[5] !== 1'b1) begin
        n_fail++; $display("FAIL blank_digits: an=%h, expected an[3]=1 an[5]=1", an);
      end
      if (an[0] === 1'b0) lows++;
    end
    n_vec++;
    if (lows != 4 * D) begin
      n_fail++; $display("FAIL blink_duty: an[0] low %0d cycles, expected %0d", lows, 4 * D);
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    repeat (400) begin
      r = {$urandom(), $urandom()};
      drive(($urandom_range(0, 15) == 0), r[39:0], 8'($urandom()));
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL random t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic test_midframe_reset();
    int acks = 0;
    for (int k = 0; k < FR && (t % FR) != 0; k++) step();
    drive(1'b1, {8{5'h0A}}, 8'h00); step();
    drive(1'b0, '0, '0);
    for (int k = 0; k < FR && (t % FR) != 4 * D + 1; k++) step();
    reset = 1'b1;
    step(); n_vec++;
    if (an !== 8'hFF || bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset: an=%h ack=%b busy=%b, expected ff 0 0", an, bus.ack, bus.busy);
    end
    reset = 1'b0;
    for (int k = 0; k < 4 * FR; k++) begin
      if (k == FR) drive(1'b1, {8{5'h03}}, 8'h00);
      else         drive(1'b0, '0, '0);
      step(); n_vec++;
      if ({an, digit, bus.busy, bus.ack} !== {exp_an, exp_digit, exp_busy, exp_ack}) begin
        n_fail++;
        $display("FAIL after_reset t=%0d: got %h %b %b %b, expected %h %b %b %b", t, an, digit, bus.busy, bus.ack, exp_an, exp_digit, exp_busy, exp_ack);
      end
      if (k < FR && bus.ack === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_fail++; $display("FAIL discarded_ack: got %0d acks, expected 0", acks);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_scan();
    test_overwrite();
    test_load_on_commit();
    test_blink_blank();
    test_random();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
